haar_feature_fetch: RTL and testbench
=====================================

HAAR_FEATURE_FETCH -- requirements
Module: haar_feature_fetch

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 14, meaning the width of the feature ROM address.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning the width of a ROM word.
REQ-003 SHALL have parameter FEATURE_BASE, default 6000, meaning the ROM word address of feature 0.
REQ-004 SHALL have parameter IDX_WIDTH, default 12, meaning the width of the feature index.
REQ-005 SHALL have port clk, input, 1 bit: single clock, all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have port req_valid, input, 1 bit: feature request valid.
REQ-008 SHALL have port req_idx, input, IDX_WIDTH bits: feature index.
REQ-009 SHALL have port req_ready, output, 1 bit: block accepts a request.
REQ-010 SHALL have port rom_addr, output, ADDR_WIDTH bits: registered address to the feature ROM.
REQ-011 SHALL have port rom_data, input, DATA_WIDTH bits: ROM read word, valid one cycle after rom_addr.
REQ-012 SHALL have port out_valid, output, 1 bit: feature record valid.
REQ-013 SHALL have port out_ready, input, 1 bit: consumer accepts the record.
REQ-014 SHALL have port out_idx, output, IDX_WIDTH bits: index of the returned feature.
REQ-015 SHALL have port out_num_rects, output, 2 bits: number of rectangles, 2 or 3.
REQ-016 SHALL have port out_threshold, output, 16 bits: signed threshold.
REQ-017 SHALL have ports out_rect0, out_rect1 and out_rect2, output, DATA_WIDTH bits each: packed rectangle words.
REQ-018 SHALL have port out_err, output, 1 bit: malformed header.

Function
REQ-019 Each feature record SHALL be 4 consecutive ROM words at FEATURE_BASE + 4*idx, in the order header, rect0, rect1, rect2.
REQ-020 The address sum SHALL be truncated to ADDR_WIDTH, so addresses wrap modulo 2^ADDR_WIDTH.
REQ-021 Header layout SHALL be: [31:16] signed threshold, [1:0] num_rects.
REQ-022 Rect word layout (passed through unmodified) SHALL be: x[31:27], y[26:22], w[21:17], h[16:12], signed weight[11:0].
REQ-023 The block SHALL use the FSM states IDLE, ISSUE, DRAIN, HOLD.
REQ-024 In IDLE, req_ready SHALL be 1; req_ready SHALL be 0 in all other states.
REQ-025 On a req_valid && req_ready edge, the block SHALL latch req_idx, set rom_addr to the header address and go to ISSUE.
REQ-026 In ISSUE, rom_addr SHALL advance by 1 per cycle through rect0, rect1 and rect2, always issuing all 4 reads, then go to DRAIN.
REQ-027 The block SHALL capture the header at the 2nd edge after acceptance and rect0, rect1, rect2 at the 3rd, 4th and 5th edges respectively.
REQ-028 When num_rects==2, the block SHALL enter HOLD after the rect1 capture (out_valid 4 cycles after acceptance), discard the rect2 read, and force out_rect2 to 0.
REQ-029 When num_rects==3, the block SHALL enter HOLD after the rect2 capture (out_valid 5 cycles after acceptance).
REQ-030 In HOLD, out_valid SHALL be 1 and all out_* SHALL remain stable while out_ready is 0.
REQ-031 On an out_valid && out_ready edge, the block SHALL return to IDLE with out_valid 0.
REQ-032 A new request SHALL NOT be accepted in the same cycle as the output handshake.
REQ-033 rom_addr SHALL hold its last value when no read is needed.

Reset
REQ-034 With rst high at an edge, the state SHALL become IDLE, and out_valid, out_err, rom_addr, out_idx, out_num_rects, out_threshold and out_rect0..2 SHALL all become 0, with req_ready 1 the following cycle.
REQ-035 Reset mid-fetch or during HOLD SHALL abandon the feature without emitting it.

Configuration
REQ-036 With FEATURE_FETCH_CHECK_EN defined, a num_rects value of 0, 1 or 3 SHALL complete as a 2-rect fetch with out_err 1, out_num_rects equal to the raw value, and out_rect0..2 all 0.
REQ-037 Without FEATURE_FETCH_CHECK_EN, out_err SHALL be tied to 0, num_rects 3 SHALL be treated as 3, and any other value SHALL be treated as 2.

Structure
REQ-038 Package haar_pkg SHALL hold the header and rect field positions and widths, WORDS_PER_FEATURE=4, and the FSM state encodings.
REQ-039 The block SHALL have no sub-module; the ROM SHALL be instantiated beside it, not inside it.

Verification
REQ-040 Reset, then idx 0 with a 3-rect header 0x0123_0003 -> rom_addr 6000..6003, out_valid at +5 cycles, out_threshold 0x0123, out_num_rects 3.
REQ-041 idx 5 with a 2-rect header -> addresses 6020..6023, out_valid at +4 cycles, out_rect2 0.
REQ-042 FEATURE_BASE=16380, idx 1 -> rom_addr 0, 1, 2, 3 (wrap).
REQ-043 Hold out_ready low for 7 cycles -> outputs stable and req_ready 0 throughout; a req_valid pulse during that time is ignored.
REQ-044 With FEATURE_FETCH_CHECK_EN, header num_rects 1 -> out_err 1 and rects 0; without it -> out_err 0, 2-rect behaviour.
REQ-045 Assert rst at cycle 3 of a fetch -> no out_valid is produced, req_ready is 1 the next cycle, and the following request completes normally.

Source files
------------

// File: rtl/haar_pkg.sv
// Shared field layout and FSM encoding for the Haar feature fetcher.
// Header: signed threshold and rect count; rect words pass through untouched.
package haar_pkg;

  localparam int WORDS_PER_FEATURE = 4;

  localparam int HDR_THR_LSB = 16;
  localparam int HDR_THR_W   = 16;
  localparam int HDR_NR_LSB  = 0;
  localparam int HDR_NR_W    = 2;

  localparam int RECT_X_LSB  = 27;
  localparam int RECT_X_W    = 5;
  localparam int RECT_Y_LSB  = 22;
  localparam int RECT_Y_W    = 5;
  localparam int RECT_W_LSB  = 17;
  localparam int RECT_W_W    = 5;
  localparam int RECT_H_LSB  = 12;
  localparam int RECT_H_W    = 5;
  localparam int RECT_WT_LSB = 0;
  localparam int RECT_WT_W   = 12;

  localparam logic [1:0] NR_TWO   = 2'd2;
  localparam logic [1:0] NR_THREE = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_e;

endpackage

// File: rtl/haar_feature_fetch.sv
// Fetches one 4-word Haar feature record from an external synchronous ROM.
// Define FEATURE_FETCH_CHECK_EN to flag headers whose rect count is not 2.
module haar_feature_fetch
  import haar_pkg::*;
#(
  parameter int ADDR_WIDTH   = 14,
  parameter int DATA_WIDTH   = 32,
  parameter int FEATURE_BASE = 6000,
  parameter int IDX_WIDTH    = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [IDX_WIDTH-1:0]  req_idx,
  output logic                  req_ready,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [IDX_WIDTH-1:0]  out_idx,
  output logic [1:0]            out_num_rects,
  output logic [15:0]           out_threshold,
  output logic [DATA_WIDTH-1:0] out_rect0,
  output logic [DATA_WIDTH-1:0] out_rect1,
  output logic [DATA_WIDTH-1:0] out_rect2,
  output logic                  out_err
);

  state_e r_state;
  state_e w_state_nxt;

  logic [2:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [IDX_WIDTH-1:0]  r_idx;
  logic [1:0]            r_nr;
  logic [15:0]           r_thr;
  logic [DATA_WIDTH-1:0] r_rect0;
  logic [DATA_WIDTH-1:0] r_rect1;
  logic [DATA_WIDTH-1:0] r_rect2;
  logic                  r_err;
  logic                  r_three;

  logic                  w_accept;
  logic                  w_busy;
  logic                  w_cap_hdr;
  logic                  w_cap_r0;
  logic                  w_cap_r1;
  logic                  w_cap_r2;
  logic [ADDR_WIDTH-1:0] w_hdr_addr;
  logic [1:0]            w_raw_nr;
  logic [1:0]            w_nr;
  logic                  w_err;
  logic                  w_three;

  assign w_hdr_addr = ADDR_WIDTH'(FEATURE_BASE)
                    + ADDR_WIDTH'(req_idx)
                    * ADDR_WIDTH'(WORDS_PER_FEATURE);

  assign w_raw_nr = rom_data[HDR_NR_LSB +: HDR_NR_W];

`ifdef FEATURE_FETCH_CHECK_EN
  // Any count other than 2 is malformed; still walk it as a 2-rect fetch.
  assign w_err   = (w_raw_nr != NR_TWO);
  assign w_nr    = w_raw_nr;
  assign w_three = 1'b0;
`else
  assign w_err   = 1'b0;
  assign w_three = (w_raw_nr == NR_THREE);
  assign w_nr    = w_three ? NR_THREE : NR_TWO;
`endif

  // r_cnt holds (edges since acceptance - 1) while the fetch is in flight.
  assign w_busy    = (r_state == ISSUE) || (r_state == DRAIN);
  assign w_cap_hdr = (r_state == ISSUE) && (r_cnt == 3'd1);
  assign w_cap_r0  = (r_state == ISSUE) && (r_cnt == 3'd2);
  assign w_cap_r1  = (r_state == DRAIN) && (r_cnt == 3'd3);
  assign w_cap_r2  = (r_state == DRAIN) && (r_cnt == 3'd4);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    out_valid   = 1'b0;
    w_accept    = 1'b0;
    unique case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (r_cnt == 3'd2) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (r_cnt == 3'd3 && !r_three) w_state_nxt = HOLD;
        else if (r_cnt == 3'd4)        w_state_nxt = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_addr  <= '0;
      r_idx   <= '0;
      r_nr    <= '0;
      r_thr   <= '0;
      r_rect0 <= '0;
      r_rect1 <= '0;
      r_rect2 <= '0;
      r_err   <= 1'b0;
      r_three <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt  <= '0;
        r_addr <= w_hdr_addr;
        r_idx  <= req_idx;
      end else if (w_busy) begin
        r_cnt <= r_cnt + 3'd1;
      end
      if (r_state == ISSUE) r_addr <= r_addr + 1'b1;
      // Clearing rects here drops any words left from the previous record.
      if (w_cap_hdr) begin
        r_thr   <= rom_data[HDR_THR_LSB +: HDR_THR_W];
        r_nr    <= w_nr;
        r_err   <= w_err;
        r_three <= w_three;
        r_rect0 <= '0;
        r_rect1 <= '0;
        r_rect2 <= '0;
      end
      if (w_cap_r0 && !r_err) r_rect0 <= rom_data;
      if (w_cap_r1 && !r_err) r_rect1 <= rom_data;
      if (w_cap_r2 && r_three) r_rect2 <= rom_data;
    end
  end

  assign rom_addr      = r_addr;
  assign out_idx       = r_idx;
  assign out_num_rects = r_nr;
  assign out_threshold = r_thr;
  assign out_rect0     = r_rect0;
  assign out_rect1     = r_rect1;
  assign out_rect2     = r_rect2;
  assign out_err       = r_err;

endmodule

// File: tb/tb_haar_feature_fetch.sv
// Randomised bench for haar_feature_fetch with a behavioural record model.
// A second instance at FEATURE_BASE=16380 covers address wrap.
module tb_haar_feature_fetch;

  localparam int AW = 14;
  localparam int DW = 32;
  localparam int IW = 12;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic [IW-1:0] req_idx = '0;
  logic          req_ready;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [IW-1:0] out_idx;
  logic [1:0]    out_num_rects;
  logic [15:0]   out_threshold;
  logic [DW-1:0] out_rect0, out_rect1, out_rect2;
  logic          out_err;

  logic          w_req_valid = 1'b0;
  logic [IW-1:0] w_req_idx = '0;
  logic          w_req_ready;
  logic [AW-1:0] w_rom_addr;
  logic [DW-1:0] w_rom_data = '0;
  logic          w_out_valid;
  logic          w_out_ready = 1'b0;
  logic [IW-1:0] w_out_idx;
  logic [1:0]    w_out_num_rects;
  logic [15:0]   w_out_threshold;
  logic [DW-1:0] w_out_rect0, w_out_rect1, w_out_rect2;
  logic          w_out_err;

  logic [DW-1:0] mem [0:DEPTH-1];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rom_data   <= mem[rom_addr];
    w_rom_data <= mem[w_rom_addr];
  end

  haar_feature_fetch #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .FEATURE_BASE(6000), .IDX_WIDTH(IW)
  ) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_idx(req_idx),
    .req_ready(req_ready), .rom_addr(rom_addr),
    .rom_data(rom_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_idx(out_idx),
    .out_num_rects(out_num_rects),
    .out_threshold(out_threshold),
    .out_rect0(out_rect0), .out_rect1(out_rect1),
    .out_rect2(out_rect2), .out_err(out_err)
  );

  haar_feature_fetch #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .FEATURE_BASE(16380), .IDX_WIDTH(IW)
  ) u_wrap (
    .clk(clk), .rst(rst),
    .req_valid(w_req_valid), .req_idx(w_req_idx),
    .req_ready(w_req_ready), .rom_addr(w_rom_addr),
    .rom_data(w_rom_data), .out_valid(w_out_valid),
    .out_ready(w_out_ready), .out_idx(w_out_idx),
    .out_num_rects(w_out_num_rects),
    .out_threshold(w_out_threshold),
    .out_rect0(w_out_rect0), .out_rect1(w_out_rect1),
    .out_rect2(w_out_rect2), .out_err(w_out_err)
  );

  // Expected record straight from the ROM image and the header rules.
  task automatic model(input int base, input int idx,
                       output int a, output int lat,
                       output logic [126:0] rec);
    logic [31:0] h, r0, r1, r2;
    logic [1:0]  raw, nr;
    logic        err, three;
    a = (base + 4 * idx) % DEPTH;
    h = mem[a];
    raw = h[1:0];
`ifdef FEATURE_FETCH_CHECK_EN
    err = (raw != 2'd2);
    nr = raw;
    three = 1'b0;
`else
    err = 1'b0;
    three = (raw == 2'd3);
    nr = three ? 2'd3 : 2'd2;
`endif
    lat = three ? 5 : 4;
    r0 = err ? 32'h0 : mem[(a + 1) % DEPTH];
    r1 = err ? 32'h0 : mem[(a + 2) % DEPTH];
    r2 = three ? mem[(a + 3) % DEPTH] : 32'h0;
    rec = {12'(idx), nr, h[31:16], err, r0, r1, r2};
  endtask

  task automatic put_rec(input int base, input int idx,
                         input logic [31:0] h,
                         input logic [31:0] r0,
                         input logic [31:0] r1,
                         input logic [31:0] r2);
    int a;
    a = (base + 4 * idx) % DEPTH;
    mem[a] = h;
    mem[(a + 1) % DEPTH] = r0;
    mem[(a + 2) % DEPTH] = r1;
    mem[(a + 3) % DEPTH] = r2;
  endtask

  function automatic logic [126:0] got_rec();
    return {out_idx, out_num_rects, out_threshold, out_err,
            out_rect0, out_rect1, out_rect2};
  endfunction

  task automatic do_fetch(input string nm, input int idx,
                          input int stall, input bit poke);
    int a, lat, seen;
    logic [126:0] exp_rec;
    model(6000, idx, a, lat, exp_rec);
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s ready_before got=%b want=1", nm, req_ready);
    end
    req_valid = 1'b1;
    req_idx = IW'(idx);
    @(posedge clk); #1;
    req_valid = 1'b0;
    seen = -1;
    for (int k = 0; k < 10; k++) begin
      if (k < 4) begin
        total++;
        if (rom_addr !== AW'((a + k) % DEPTH)) begin
          bad++;
          $display("FAIL %s addr%0d got=%0d want=%0d",
                   nm, k, rom_addr, (a + k) % DEPTH);
        end
      end
      if (out_valid === 1'b1) begin
        seen = k;
        break;
      end
      @(posedge clk); #1;
    end
    total++;
    if (seen != lat) begin
      bad++;
      $display("FAIL %s latency got=%0d want=%0d", nm, seen, lat);
    end
    if (seen < 0) return;
    total++;
    if (got_rec() !== exp_rec) begin
      bad++;
      $display("FAIL %s record got=%h want=%h", nm, got_rec(), exp_rec);
    end
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      if (poke && s == 1) req_valid = 1'b1;
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b1 || req_ready !== 1'b0 ||
          got_rec() !== exp_rec) begin
        bad++;
        $display("FAIL %s stall%0d v=%b r=%b rec=%h want=%h",
                 nm, s, out_valid, req_ready, got_rec(), exp_rec);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0 || req_ready !== 1'b1 ||
        rom_addr !== AW'((a + 3) % DEPTH)) begin
      bad++;
      $display("FAIL %s handshake v=%b r=%b addr=%0d want_addr=%0d",
               nm, out_valid, req_ready, rom_addr, (a + 3) % DEPTH);
    end
    @(negedge clk);
    out_ready = 1'b0;
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (req_ready !== 1'b1 || out_valid !== 1'b0 || rom_addr !== '0 ||
        got_rec() !== '0 || w_rom_addr !== '0 || w_out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset r=%b v=%b addr=%0d rec=%h",
               req_ready, out_valid, rom_addr, got_rec());
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_three_rect();
    put_rec(6000, 0, 32'h0123_0003, 32'h1111_1111,
            32'h2222_2222, 32'h3333_3333);
    do_fetch("three_rect", 0, 0, 1'b0);
  endtask

  task automatic test_two_rect();
    put_rec(6000, 5, 32'hFF80_0002, 32'hA5A5_0001,
            32'h5A5A_0FFF, 32'hDEAD_BEEF);
    do_fetch("two_rect", 5, 0, 1'b0);
  endtask

  task automatic test_stall();
    put_rec(6000, 9, 32'h7FFF_0003, 32'h0808_4321,
            32'h1234_5678, 32'h9ABC_DEF0);
    do_fetch("stall", 9, 7, 1'b1);
  endtask

  task automatic test_bad_count();
    put_rec(6000, 17, 32'h0042_0001, 32'hCAFE_0001,
            32'hBEEF_0002, 32'hF00D_0003);
    do_fetch("nr_one", 17, 1, 1'b0);
    put_rec(6000, 18, 32'h8001_0000, 32'h0101_0101,
            32'h0202_0202, 32'h0303_0303);
    do_fetch("nr_zero", 18, 0, 1'b0);
  endtask

  task automatic test_wrap();
    int a, lat, seen;
    logic [126:0] rec;
    put_rec(16380, 1, 32'h0555_0003, 32'h1000_0001,
            32'h2000_0002, 32'h3000_0003);
    model(16380, 1, a, lat, rec);
    @(negedge clk);
    w_req_valid = 1'b1;
    w_req_idx = 12'd1;
    @(posedge clk); #1;
    w_req_valid = 1'b0;
    seen = -1;
    for (int k = 0; k < 10; k++) begin
      if (k < 4) begin
        total++;
        if (w_rom_addr !== AW'(k)) begin
          bad++;
          $display("FAIL wrap addr%0d got=%0d want=%0d",
                   k, w_rom_addr, k);
        end
      end
      if (w_out_valid === 1'b1) begin
        seen = k;
        break;
      end
      @(posedge clk); #1;
    end
    total++;
    if (seen != lat || w_out_threshold !== rec[112:97] ||
        w_out_rect2 !== rec[31:0]) begin
      bad++;
      $display("FAIL wrap result lat=%0d want=%0d thr=%h r2=%h",
               seen, lat, w_out_threshold, w_out_rect2);
    end
    @(negedge clk);
    w_out_ready = 1'b1;
    @(negedge clk);
    w_out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_fetch();
    put_rec(6000, 33, 32'h0100_0003, 32'h1, 32'h2, 32'h3);
    @(negedge clk);
    req_valid = 1'b1;
    req_idx = 12'd33;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if (req_ready !== 1'b1 || out_valid !== 1'b0 || rom_addr !== '0) begin
      bad++;
      $display("FAIL mid_reset r=%b v=%b addr=%0d",
               req_ready, out_valid, rom_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL mid_reset_emit cyc%0d got=%b want=0", k, out_valid);
      end
    end
    do_fetch("after_reset", 33, 0, 1'b0);
  endtask

  task automatic test_random();
    int idx;
    logic [31:0] h;
    for (int n = 0; n < 12; n++) begin
      idx = int'($urandom_range(0, 4095));
      h = $urandom;
      put_rec(6000, idx, h, $urandom, $urandom, $urandom);
      do_fetch("random", idx, int'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    test_reset();
    test_three_rect();
    test_two_rect();
    test_stall();
    test_bad_count();
    test_wrap();
    test_reset_mid_fetch();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
